// File: rtl/board_uart_tx_if.sv
// board_uart_tx_if: snapshot request, board/generation inputs and UART line outputs.
interface board_uart_tx_if;
   logic         start;
   logic [255:0] board;
   logic [15:0]  generation;
   logic         tx;
   logic         busy;
   logic         done;
   modport master(output start, board, generation, input tx, busy, done);
   modport slave(input start, board, generation, output tx, busy, done);
endinterface

// File: rtl/board_uart_tx.sv
// board_uart_tx: sends header, generation, board and checksum as a 36-byte 8N1 UART packet.
module board_uart_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input logic           clk,
   input logic           reset,
   board_uart_tx_if.slave bus
);
   localparam int W = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t       state, state_n;
   logic [W-1:0] baud, baud_n;
   logic [2:0]   bit_idx, bit_n;
   logic [5:0]   byte_idx, byte_n;
   logic [7:0]   csum, csum_n, cur;
   logic [255:0] snap, snap_n;
   logic [15:0]  gen, gen_n;
   logic         tx, tx_n, done, done_n, tick;
   assign tick = baud == W'(CLKS_PER_BIT - 1);
   // snap shifts left after each board byte, so its top byte is always the next one to send
   assign cur = byte_idx == 6'd0  ? 8'hA5 :
                byte_idx == 6'd1  ? gen[15:8] :
                byte_idx == 6'd2  ? gen[7:0] :
                byte_idx == 6'd35 ? csum : snap[255:248];
   assign bus.tx   = tx;
   assign bus.busy = state != IDLE;
   assign bus.done = done;
   always_comb begin
      state_n = state;
      baud_n  = (state == IDLE || tick) ? '0 : baud + 1'b1;
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      csum_n  = csum;
      snap_n  = snap;
      gen_n   = gen;
      tx_n    = tx;
      done_n  = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            state_n = START;
            tx_n    = 1'b0;
            bit_n   = 3'd0;
            byte_n  = 6'd0;
            csum_n  = 8'd0;
            snap_n  = bus.board;
            gen_n   = bus.generation;
         end
         START: if (tick) begin
            state_n = DATA;
            tx_n    = cur[0];
         end
         DATA: if (tick) begin
            bit_n   = bit_idx + 3'd1;
            state_n = bit_idx == 3'd7 ? STOP : DATA;
            tx_n    = bit_idx == 3'd7 ? 1'b1 : cur[bit_n];
         end
         STOP: if (tick) begin
            csum_n  = csum + ((byte_idx >= 6'd1 && byte_idx <= 6'd34) ? cur : 8'd0);
            snap_n  = (byte_idx >= 6'd3 && byte_idx <= 6'd34) ? {snap[247:0], 8'd0} : snap;
            state_n = byte_idx == 6'd35 ? IDLE : START;
            done_n  = byte_idx == 6'd35;
            tx_n    = byte_idx == 6'd35;
            byte_n  = byte_idx == 6'd35 ? 6'd0 : byte_idx + 6'd1;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= 3'd0;
         byte_idx <= 6'd0;
         csum     <= 8'd0;
         snap     <= '0;
         gen      <= 16'd0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         csum     <= csum_n;
         snap     <= snap_n;
         gen      <= gen_n;
         tx       <= tx_n;
         done     <= done_n;
      end
   end
endmodule
